// File: rtl/mp_regfile_pkg.sv
// -----------------------------------------------------------------------------
// mp_regfile_pkg
// Shared constants and helpers for the multi-port register file.
//   CNT_W    : width of the collision counter
//   CNT_MAX  : saturation value of the collision counter
//   sat_inc  : saturating increment for the collision counter
// -----------------------------------------------------------------------------
package mp_regfile_pkg;

   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      return (value == CNT_MAX) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/mp_regfile_if.sv
// -----------------------------------------------------------------------------
// mp_regfile_if
// Bundles the write-back, invalidate, read and collision signals of
// mp_regfile.
//   master : drives writes, invalidates and read requests; observes results
//   slave  : the register file itself
// Signals:
//   wr_en_i / wr_addr_i / wr_data_i    NUM_WR write ports, port 0 highest priority
//   inval_en_i / inval_addr_i          clear the ready bit of one entry
//   rd_en_i / rd_addr_i                NUM_RD read requests
//   rd_data_o / rd_ready_o             combinational read results
//   collision_o / collision_cnt_o      registered collision pulse and count
// -----------------------------------------------------------------------------
interface mp_regfile_if
   import mp_regfile_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32,
   parameter int NUM_WR     = 6,
   parameter int NUM_RD     = 2
);
   localparam int AW = $clog2(DEPTH);

   logic [NUM_WR-1:0]                 wr_en_i;
   logic [NUM_WR-1:0][AW-1:0]         wr_addr_i;
   logic [NUM_WR-1:0][DATA_WIDTH-1:0] wr_data_i;
   logic                              inval_en_i;
   logic [AW-1:0]                     inval_addr_i;
   logic [NUM_RD-1:0]                 rd_en_i;
   logic [NUM_RD-1:0][AW-1:0]         rd_addr_i;
   logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data_o;
   logic [NUM_RD-1:0]                 rd_ready_o;
   logic                              collision_o;
   logic [CNT_W-1:0]                  collision_cnt_o;

   modport master (
      output wr_en_i, wr_addr_i, wr_data_i,
      output inval_en_i, inval_addr_i,
      output rd_en_i, rd_addr_i,
      input  rd_data_o, rd_ready_o,
      input  collision_o, collision_cnt_o
   );

   modport slave (
      input  wr_en_i, wr_addr_i, wr_data_i,
      input  inval_en_i, inval_addr_i,
      input  rd_en_i, rd_addr_i,
      output rd_data_o, rd_ready_o,
      output collision_o, collision_cnt_o
   );

endinterface

// File: rtl/mp_regfile_wr_arb.sv
// -----------------------------------------------------------------------------
// mp_regfile_wr_arb
// Priority select of the write ports for one register-file entry (ENTRY).
// Ports:
//   wr_en, wr_addr, wr_data : all write ports
//   we                      : some enabled port targets this entry
//   data                    : data of the lowest-index matching port
//   multi_hit               : two or more enabled ports target this entry
// -----------------------------------------------------------------------------
module mp_regfile_wr_arb #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WR     = 6,
   parameter int AW         = 5,
   parameter int ENTRY      = 0
) (
   input  logic [NUM_WR-1:0]                 wr_en,
   input  logic [NUM_WR-1:0][AW-1:0]         wr_addr,
   input  logic [NUM_WR-1:0][DATA_WIDTH-1:0] wr_data,
   output logic                              we,
   output logic [DATA_WIDTH-1:0]             data,
   output logic                              multi_hit
);

   localparam logic [AW-1:0] ENTRY_ADDR = AW'(ENTRY);

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves
      // it unassigned, which would otherwise infer a latch.
      we        = 1'b0;
      data      = '0;
      multi_hit = 1'b0;
      // Ascending scan: the first hit wins, any later hit is a collision.
      for (int p = 0; p < NUM_WR; p++) begin
         if (wr_en[p] && (wr_addr[p] == ENTRY_ADDR)) begin
            if (we) begin
               multi_hit = 1'b1;
            end else begin
               we   = 1'b1;
               data = wr_data[p];
            end
         end
      end
   end

endmodule

// File: rtl/mp_regfile.sv
// -----------------------------------------------------------------------------
// mp_regfile
// Multi-port register file with per-entry ready bits and write-collision
// tracking. Sits between the write-back buses and the operand read ports of
// the issue stage.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : mp_regfile_if.slave (writes, invalidate, reads, collision status)
// Parameters:
//   DATA_WIDTH, DEPTH (power of two), NUM_WR, NUM_RD
//   ZERO_REG : when 1, entry 0 is hard-wired to 0/ready
// Build option:
//   MP_REGFILE_BYPASS_EN : same-cycle winning write data is forwarded to reads
// -----------------------------------------------------------------------------
module mp_regfile
   import mp_regfile_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32,
   parameter int NUM_WR     = 6,
   parameter int NUM_RD     = 2,
   parameter int ZERO_REG   = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   mp_regfile_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0]      ready;
   logic                  collision_q;
   logic [CNT_W-1:0]      cnt_q;

   logic [DEPTH-1:0]      entry_we;
   logic [DEPTH-1:0]      entry_multi;
   logic [DEPTH-1:0]      entry_inval;
   logic [DATA_WIDTH-1:0] entry_data [DEPTH];
   logic                  collision_now;

   logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data;
   logic [NUM_RD-1:0]                 rd_ready;

   // Per-entry write resolution. A hard-wired zero entry has its write,
   // invalidate and collision contributions masked off here so the rest of
   // the design needs no special case for it.
   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      localparam bit IS_ZERO = (ZERO_REG != 0) && (g == 0);

      logic                  arb_we;
      logic                  arb_multi;
      logic [DATA_WIDTH-1:0] arb_data;

      mp_regfile_wr_arb #(
         .DATA_WIDTH (DATA_WIDTH),
         .NUM_WR     (NUM_WR),
         .AW         (AW),
         .ENTRY      (g)
      ) u_wr_arb (
         .wr_en     (bus.wr_en_i),
         .wr_addr   (bus.wr_addr_i),
         .wr_data   (bus.wr_data_i),
         .we        (arb_we),
         .data      (arb_data),
         .multi_hit (arb_multi)
      );

      assign entry_we[g]    = arb_we & ~IS_ZERO;
      assign entry_multi[g] = arb_multi & ~IS_ZERO;
      assign entry_data[g]  = arb_data;
      assign entry_inval[g] = bus.inval_en_i && (bus.inval_addr_i == AW'(g)) && !IS_ZERO;
   end

   // One collision cycle no matter how many entries were hit at once.
   assign collision_now = |entry_multi;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the storage array is reset too, because every entry must
         // read back as 0 straight out of reset.
         for (int e = 0; e < DEPTH; e++) begin
            mem[e] <= '0;
         end
         ready       <= '1;
         collision_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         // NOTE: non-blocking assignments so every entry updates from the
         // same pre-edge values, independent of statement order.
         for (int e = 0; e < DEPTH; e++) begin
            if (entry_we[e]) begin
               mem[e] <= entry_data[e];
            end
            // A new producer dispatched in the same cycle outranks the
            // write-back, so the entry stays not-ready.
            if (entry_inval[e]) begin
               ready[e] <= 1'b0;
            end else if (entry_we[e]) begin
               ready[e] <= 1'b1;
            end
         end
         collision_q <= collision_now;
         if (collision_now) begin
            cnt_q <= sat_inc(cnt_q);
         end
      end
   end

   always_comb begin
      rd_data  = '0;
      rd_ready = '0;
      for (int r = 0; r < NUM_RD; r++) begin
         if (bus.rd_en_i[r]) begin
            rd_data[r]  = mem[bus.rd_addr_i[r]];
            rd_ready[r] = ready[bus.rd_addr_i[r]];
`ifdef MP_REGFILE_BYPASS_EN
            // Forward the winning write; a same-cycle invalidate still
            // shows as not-ready.
            if (entry_we[bus.rd_addr_i[r]]) begin
               rd_data[r]  = entry_data[bus.rd_addr_i[r]];
               rd_ready[r] = ~entry_inval[bus.rd_addr_i[r]];
            end
`endif
         end
      end
   end

   assign bus.rd_data_o       = rd_data;
   assign bus.rd_ready_o      = rd_ready;
   assign bus.collision_o     = collision_q;
   assign bus.collision_cnt_o = cnt_q;

endmodule

// File: tb/tb_mp_regfile.sv
// -----------------------------------------------------------------------------
// tb_mp_regfile
// Drives two register files with identical stimulus: a default instance and
// one with ZERO_REG=1. A behavioural model predicts both; it is compared on
// every falling edge, and directed steps also check hand-computed values.
// -----------------------------------------------------------------------------
module tb_mp_regfile;

   localparam int DW    = 32;
   localparam int DEPTH = 32;
   localparam int NW    = 6;
   localparam int NR    = 2;
   localparam int AW    = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   logic [NW-1:0]          wr_en      = '0;
   logic [NW-1:0][AW-1:0]  wr_addr    = '0;
   logic [NW-1:0][DW-1:0]  wr_data    = '0;
   logic                   inval_en   = 1'b0;
   logic [AW-1:0]          inval_addr = '0;
   logic [NR-1:0]          rd_en      = '0;
   logic [NR-1:0][AW-1:0]  rd_addr    = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mp_regfile_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_WR(NW), .NUM_RD(NR)) bus ();
   mp_regfile_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_WR(NW), .NUM_RD(NR)) bus_z ();

   assign bus.wr_en_i        = wr_en;
   assign bus.wr_addr_i      = wr_addr;
   assign bus.wr_data_i      = wr_data;
   assign bus.inval_en_i     = inval_en;
   assign bus.inval_addr_i   = inval_addr;
   assign bus.rd_en_i        = rd_en;
   assign bus.rd_addr_i      = rd_addr;
   assign bus_z.wr_en_i      = wr_en;
   assign bus_z.wr_addr_i    = wr_addr;
   assign bus_z.wr_data_i    = wr_data;
   assign bus_z.inval_en_i   = inval_en;
   assign bus_z.inval_addr_i = inval_addr;
   assign bus_z.rd_en_i      = rd_en;
   assign bus_z.rd_addr_i    = rd_addr;

   mp_regfile #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_WR(NW), .NUM_RD(NR), .ZERO_REG(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   mp_regfile #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_WR(NW), .NUM_RD(NR), .ZERO_REG(1)) dut_z (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_z)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (k=0 default, k=1 ZERO_REG) ----------
   logic [DW-1:0] m_data  [2][DEPTH];
   bit            m_ready [2][DEPTH];
   bit            m_coll  [2];
   int            m_cnt   [2];

   function automatic bit writable(input int k, input int a);
      return !(k == 1 && a == 0);
   endfunction

   function automatic bit win_hit(input int k, input int a);
      for (int p = 0; p < NW; p++)
         if (wr_en[p] && int'(wr_addr[p]) == a && writable(k, a)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [DW-1:0] win_data(input int k, input int a);
      for (int p = 0; p < NW; p++)
         if (wr_en[p] && int'(wr_addr[p]) == a && writable(k, a)) return wr_data[p];
      return '0;
   endfunction

   function automatic bit any_coll(input int k);
      for (int p = 0; p < NW; p++)
         for (int q = p + 1; q < NW; q++)
            if (wr_en[p] && wr_en[q] && wr_addr[p] == wr_addr[q] && writable(k, int'(wr_addr[p])))
               return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < DEPTH; a++) begin
               m_data[k][a]  <= '0;
               m_ready[k][a] <= 1'b1;
            end
            m_coll[k] <= 1'b0;
            m_cnt[k]  <= 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < DEPTH; a++) begin
               if (win_hit(k, a)) m_data[k][a] <= win_data(k, a);
               if (inval_en && int'(inval_addr) == a && writable(k, a)) m_ready[k][a] <= 1'b0;
               else if (win_hit(k, a)) m_ready[k][a] <= 1'b1;
            end
            m_coll[k] <= any_coll(k);
            if (any_coll(k) && m_cnt[k] < 65535) m_cnt[k] <= m_cnt[k] + 1;
         end
      end
   end

   task automatic compare(input int k, input logic [NR-1:0][DW-1:0] d, input logic [NR-1:0] rdy,
                          input logic coll, input logic [15:0] cnt);
      logic [DW-1:0] ed;
      logic          er;
      int            a;
      for (int r = 0; r < NR; r++) begin
         ed = '0;
         er = 1'b0;
         a  = int'(rd_addr[r]);
         if (rd_en[r]) begin
            ed = m_data[k][a];
            er = m_ready[k][a];
`ifdef MP_REGFILE_BYPASS_EN
            if (win_hit(k, a)) begin
               ed = win_data(k, a);
               er = !(inval_en && int'(inval_addr) == a);
            end
`endif
         end
         check($sformatf("model i%0d rd%0d data", k, r), 64'(d[r]), 64'(ed));
         check($sformatf("model i%0d rd%0d ready", k, r), 64'(rdy[r]), 64'(er));
      end
      check($sformatf("model i%0d collision", k), 64'(coll), 64'(m_coll[k]));
      check($sformatf("model i%0d count", k), 64'(cnt), 64'(m_cnt[k]));
   endtask

   always @(negedge clk) begin
      compare(0, bus.rd_data_o, bus.rd_ready_o, bus.collision_o, bus.collision_cnt_o);
      compare(1, bus_z.rd_data_o, bus_z.rd_ready_o, bus_z.collision_o, bus_z.collision_cnt_o);
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      wr_en    = '0;
      wr_addr  = '0;
      wr_data  = '0;
      inval_en = 1'b0;
      rd_en    = '0;
      rd_addr  = '0;
   endtask

   task automatic wr(input int p, input int a, input logic [DW-1:0] d);
      wr_en[p]   = 1'b1;
      wr_addr[p] = AW'(a);
      wr_data[p] = d;
   endtask

   task automatic rd(input int r, input int a);
      rd_en[r]   = 1'b1;
      rd_addr[r] = AW'(a);
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;

      // Reset contents: enabled reads give 0/ready, disabled give 0/0.
      rd(0, 3);
      rd(1, 7);
      @(negedge clk);
      check("reset rd0 data", 64'(bus.rd_data_o[0]), 64'h0);
      check("reset rd0 ready", 64'(bus.rd_ready_o[0]), 64'h1);
      check("reset rd1 ready", 64'(bus.rd_ready_o[1]), 64'h1);
      check("reset collision", 64'(bus.collision_o), 64'h0);
      check("reset count", 64'(bus.collision_cnt_o), 64'h0);
      tick();
      rd_en = '0;
      @(negedge clk);
      check("disabled rd0 data", 64'(bus.rd_data_o[0]), 64'h0);
      check("disabled rd1 ready", 64'(bus.rd_ready_o[1]), 64'h0);

      // Single write, port 2 -> entry 5.
      tick();
      wr(2, 5, 32'hDEAD_BEEF);
      rd(0, 5);
      @(negedge clk);
`ifdef MP_REGFILE_BYPASS_EN
      check("same-cycle rd5 data", 64'(bus.rd_data_o[0]), 64'hDEAD_BEEF);
`else
      check("same-cycle rd5 data", 64'(bus.rd_data_o[0]), 64'h0);
`endif
      check("same-cycle rd5 ready", 64'(bus.rd_ready_o[0]), 64'h1);
      tick();
      wr_en = '0;
      @(negedge clk);
      check("rd5 data", 64'(bus.rd_data_o[0]), 64'hDEAD_BEEF);
      check("rd5 ready", 64'(bus.rd_ready_o[0]), 64'h1);

      // Ports 1 and 4 collide on entry 9: port 1 wins.
      tick();
      clear_inputs();
      wr(1, 9, 32'h11);
      wr(4, 9, 32'h44);
      rd(1, 9);
      @(negedge clk);
      check("collision before edge", 64'(bus.collision_o), 64'h0);
      tick();
      wr_en = '0;
      @(negedge clk);
      check("rd9 data", 64'(bus.rd_data_o[1]), 64'h11);
      check("collision pulse", 64'(bus.collision_o), 64'h1);
      check("count after 1", 64'(bus.collision_cnt_o), 64'h1);
      tick();
      @(negedge clk);
      check("collision cleared", 64'(bus.collision_o), 64'h0);
      check("count held", 64'(bus.collision_cnt_o), 64'h1);

      // Invalidate plus write on entry 12: data lands, ready ends 0.
      tick();
      clear_inputs();
      wr(0, 12, 32'h55);
      inval_en   = 1'b1;
      inval_addr = AW'(12);
      rd(0, 12);
      @(negedge clk);
`ifdef MP_REGFILE_BYPASS_EN
      check("inval+wr bypass data", 64'(bus.rd_data_o[0]), 64'h55);
      check("inval+wr bypass ready", 64'(bus.rd_ready_o[0]), 64'h0);
`else
      check("inval+wr same-cycle ready", 64'(bus.rd_ready_o[0]), 64'h1);
`endif
      tick();
      wr_en    = '0;
      inval_en = 1'b0;
      @(negedge clk);
      check("rd12 data", 64'(bus.rd_data_o[0]), 64'h55);
      check("rd12 ready", 64'(bus.rd_ready_o[0]), 64'h0);
      tick();
      wr(3, 12, 32'h66);
      tick();
      wr_en = '0;
      @(negedge clk);
      check("rd12 rewrite data", 64'(bus.rd_data_o[0]), 64'h66);
      check("rd12 rewrite ready", 64'(bus.rd_ready_o[0]), 64'h1);
      // Invalidate alone: ready drops only after the edge.
      tick();
      inval_en   = 1'b1;
      inval_addr = AW'(12);
      @(negedge clk);
      check("inval same-cycle ready", 64'(bus.rd_ready_o[0]), 64'h1);
      tick();
      inval_en = 1'b0;
      @(negedge clk);
      check("inval ready low", 64'(bus.rd_ready_o[0]), 64'h0);
      check("inval keeps data", 64'(bus.rd_data_o[0]), 64'h66);

      // Two ports write entry 0: ignored by the ZERO_REG instance.
      tick();
      clear_inputs();
      wr(0, 0, 32'hFF);
      wr(1, 0, 32'hFF);
      rd(0, 0);
      tick();
      wr_en = '0;
      @(negedge clk);
      check("zero rd0 data", 64'(bus_z.rd_data_o[0]), 64'h0);
      check("zero rd0 ready", 64'(bus_z.rd_ready_o[0]), 64'h1);
      check("zero collision", 64'(bus_z.collision_o), 64'h0);
      check("zero count", 64'(bus_z.collision_cnt_o), 64'h1);
      check("plain rd0 data", 64'(bus.rd_data_o[0]), 64'hFF);
      check("plain collision", 64'(bus.collision_o), 64'h1);
      check("plain count", 64'(bus.collision_cnt_o), 64'h2);
      tick();
      inval_en   = 1'b1;
      inval_addr = '0;
      tick();
      inval_en = 1'b0;
      @(negedge clk);
      check("zero inval ignored", 64'(bus_z.rd_ready_o[0]), 64'h1);
      check("plain inval entry0", 64'(bus.rd_ready_o[0]), 64'h0);

      // Mixed traffic on a few hot entries, checked by the model only.
      for (int i = 0; i < 300; i++) begin
         tick();
         clear_inputs();
         for (int p = 0; p < NW; p++)
            if ($urandom_range(0, 2) == 0) wr(p, ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(8, 12), $urandom);
         inval_en   = ($urandom_range(0, 3) == 0);
         inval_addr = AW'($urandom_range(8, 12));
         for (int r = 0; r < NR; r++)
            if ($urandom_range(0, 3) != 0) rd(r, $urandom_range(0, 12));
      end

      // Back-to-back collisions long enough to saturate the counter.
      tick();
      clear_inputs();
      wr(0, 9, 32'h1);
      wr(1, 9, 32'h2);
      repeat (65540) tick();
      @(negedge clk);
      check("saturated count", 64'(bus.collision_cnt_o), 64'hFFFF);
      check("saturated count z", 64'(bus_z.collision_cnt_o), 64'hFFFF);
      check("saturated collision", 64'(bus.collision_o), 64'h1);

      // Asynchronous reset mid-stream, observed before any edge.
      tick();
      rst_n = 1'b0;
      rd(0, 9);
      #1;
      check("async rst count", 64'(bus.collision_cnt_o), 64'h0);
      check("async rst collision", 64'(bus.collision_o), 64'h0);
      check("async rst count z", 64'(bus_z.collision_cnt_o), 64'h0);
      check("async rst rd data", 64'(bus.rd_data_o[0]), 64'h0);
      check("async rst rd ready", 64'(bus.rd_ready_o[0]), 64'h1);
      tick();
      rst_n = 1'b1;
      clear_inputs();
      wr(0, 5, 32'hA5A5);
      rd(0, 5);
      tick();
      wr_en = '0;
      @(negedge clk);
      check("post-reset write", 64'(bus.rd_data_o[0]), 64'hA5A5);
      check("post-reset count", 64'(bus.collision_cnt_o), 64'h0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
